// File: rtl/sdrc_dev_rsp.sv
// sdrc_dev_rsp - SDRAM device responder (memory side of the SDRAM pins).
//
// Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and the mode
// register, stores write bursts into an internal array and returns read
// bursts after the programmed CAS latency. proto_err is a sticky flag
// raised on protocol violations seen on the controller's pins.
//
// Ports:
//   sdram_clk, sdram_rst   clock, asynchronous active-high reset
//   sdr_cke                clock enable (0 = all registers hold)
//   sdr_cs_n/ras_n/cas_n/we_n, sdr_ba, sdr_addr   command bus
//   sdr_dqm, sdr_dq_in     write byte mask (1 = masked) and write data
//   sdr_dq_out, sdr_dq_oe  read data and its drive enable
//   bank_open              per-bank row-open flags
//   proto_err              sticky protocol-error flag
//
// Build option: define SDRC_DEV_RSP_TIMING_CHK_EN to add per-bank cycle
// counters and tRCD / tRP / tRFC violation checks to proto_err.
//
// Handshake: there is no valid/ready pair; a command is accepted on every
// rising edge with sdr_cke = 1 and sdr_cs_n = 0, and a read beat is valid on
// every cycle where sdr_dq_oe = 1.
module sdrc_dev_rsp #(
  parameter int SDR_DW = 16,
  parameter int SDR_BW = 2,
  parameter int SDR_AW = 13,
  parameter int COL_W  = 8,
  parameter int MEM_AW = 12
) (
  input  logic              sdram_clk,
  input  logic              sdram_rst,
  input  logic              sdr_cke,
  input  logic              sdr_cs_n,
  input  logic              sdr_ras_n,
  input  logic              sdr_cas_n,
  input  logic              sdr_we_n,
  input  logic [1:0]        sdr_ba,
  input  logic [SDR_AW-1:0] sdr_addr,
  input  logic [SDR_BW-1:0] sdr_dqm,
  input  logic [SDR_DW-1:0] sdr_dq_in,
  output logic [SDR_DW-1:0] sdr_dq_out,
  output logic              sdr_dq_oe,
  output logic [3:0]        bank_open,
  output logic              proto_err
);

  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_BT  = 3'b110;
  localparam logic [2:0] CMD_NOP = 3'b111;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RD = 2'd1, ST_WR = 2'd2} bst_state_e;

  // Column advance that wraps inside the BL-aligned block (m = BL-1).
  function automatic logic [COL_W-1:0] col_next(input logic [COL_W-1:0] c, input logic [2:0] m);
    logic [COL_W-1:0] msk;
    msk = {{(COL_W-3){1'b0}}, m};
    return (c & ~msk) | ((c + 1'b1) & msk);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_idx(input logic [SDR_AW-1:0] row,
                                                input logic [1:0] ba,
                                                input logic [COL_W-1:0] col);
    return MEM_AW'({row, ba, col});
  endfunction

  logic [SDR_DW-1:0] mem [2**MEM_AW];
  logic [SDR_DW-1:0] rd_data_q;

  logic [SDR_AW-1:0]       mode_q, mode_d;
  logic [3:0]              bank_open_q, bank_open_d;
  logic [3:0][SDR_AW-1:0]  row_q, row_d;
  logic                    proto_err_q, proto_err_d;
  bst_state_e              st_q, st_d;
  logic [1:0]              bst_ba_q, bst_ba_d;
  logic [COL_W-1:0]        bst_col_q, bst_col_d;
  logic [2:0]              rem_q, rem_d;
  logic                    bst_ap_q, bst_ap_d;
  logic                    rd_vld_q, rd_vld_d;
  logic                    p1_vld_q, p1_vld_d;
  logic [SDR_DW-1:0]       p1_data_q, p1_data_d;
  logic [SDR_DW-1:0]       dq_out_q, dq_out_d;
  logic                    dq_oe_q, dq_oe_d;

  logic [2:0]        cmd;
  logic [2:0]        bl_m1;
  logic              cl2;
  logic              any_open;
  logic              is_rw;
  logic              rw_ok;
  logic              tim_err;
  logic              beat_vld, beat_rd, beat_last, beat_ap;
  logic [1:0]        beat_ba;
  logic [COL_W-1:0]  beat_col;
  logic [MEM_AW-1:0] beat_idx;
  logic              unused_mode_bits;

  assign cmd      = sdr_cs_n ? CMD_NOP : {sdr_ras_n, sdr_cas_n, sdr_we_n};
  assign cl2      = (mode_q[6:4] == 3'd2);
  assign any_open = |bank_open_q;
  assign is_rw    = (cmd == CMD_RD) || (cmd == CMD_WR);
  assign rw_ok    = is_rw && bank_open_q[sdr_ba];
  assign unused_mode_bits = ^{mode_q[SDR_AW-1:7], mode_q[3]};

  always_comb begin
    case (mode_q[2:0])
      3'd0:    bl_m1 = 3'd0;
      3'd1:    bl_m1 = 3'd1;
      3'd2:    bl_m1 = 3'd3;
      default: bl_m1 = 3'd7;
    endcase
  end

  // Beat issued at this edge: a new READ/WRITE wins over the running burst,
  // BURST TERMINATE suppresses the engine's beat.
  always_comb begin
    beat_vld  = (st_q != ST_IDLE) && (cmd != CMD_BT);
    beat_rd   = (st_q == ST_RD);
    beat_ba   = bst_ba_q;
    beat_col  = bst_col_q;
    beat_last = (rem_q == 3'd1);
    beat_ap   = bst_ap_q;
    if (rw_ok) begin
      beat_vld  = 1'b1;
      beat_rd   = (cmd == CMD_RD);
      beat_ba   = sdr_ba;
      beat_col  = sdr_addr[COL_W-1:0];
      beat_last = (bl_m1 == 3'd0);
      beat_ap   = sdr_addr[10];
    end
    beat_idx = mem_idx(row_q[beat_ba], beat_ba, beat_col);
  end

  // Command, bank and burst-engine next state.
  always_comb begin
    mode_d      = mode_q;
    bank_open_d = bank_open_q;
    row_d       = row_q;
    st_d        = st_q;
    bst_ba_d    = bst_ba_q;
    bst_col_d   = bst_col_q;
    rem_d       = rem_q;
    bst_ap_d    = bst_ap_q;

    case (cmd)
      CMD_ACT: begin
        bank_open_d[sdr_ba] = 1'b1;
        row_d[sdr_ba]       = sdr_addr;
      end
      CMD_PRE: begin
        if (sdr_addr[10]) bank_open_d = 4'b0000;
        else              bank_open_d[sdr_ba] = 1'b0;
      end
      CMD_LMR: if (!any_open) mode_d = sdr_addr;
      default: ;
    endcase

    if (beat_vld) begin
      bst_ba_d  = beat_ba;
      bst_ap_d  = beat_ap;
      bst_col_d = col_next(beat_col, bl_m1);
      if (beat_last) begin
        st_d  = ST_IDLE;
        rem_d = 3'd0;
        if (beat_ap) bank_open_d[beat_ba] = 1'b0;
      end else if (rw_ok) begin
        st_d  = (cmd == CMD_RD) ? ST_RD : ST_WR;
        rem_d = bl_m1;
      end else begin
        rem_d = rem_q - 3'd1;
      end
    end else if (cmd == CMD_BT) begin
      st_d  = ST_IDLE;
      rem_d = 3'd0;
    end

    proto_err_d = proto_err_q
                | ((cmd == CMD_ACT) && bank_open_q[sdr_ba])
                | (is_rw && !bank_open_q[sdr_ba])
                | (((cmd == CMD_LMR) || (cmd == CMD_REF)) && any_open)
                | ((cmd == CMD_WR) && dq_oe_q)
                | tim_err;
  end

  // Read return pipeline: array register (stage 0), stage 1, output register.
  // The output register taps stage 0 for CL2 and stage 1 for CL3.
  always_comb begin
    rd_vld_d  = beat_vld && beat_rd;
    p1_vld_d  = rd_vld_q;
    p1_data_d = rd_data_q;
    if (cl2) begin
      dq_oe_d  = rd_vld_q;
      dq_out_d = rd_vld_q ? rd_data_q : '0;
    end else begin
      dq_oe_d  = p1_vld_q;
      dq_out_d = p1_vld_q ? p1_data_q : '0;
    end
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      mode_q      <= SDR_AW'(13'h030);
      bank_open_q <= '0;
      row_q       <= '0;
      proto_err_q <= 1'b0;
      st_q        <= ST_IDLE;
      bst_ba_q    <= '0;
      bst_col_q   <= '0;
      rem_q       <= '0;
      bst_ap_q    <= 1'b0;
      rd_vld_q    <= 1'b0;
      p1_vld_q    <= 1'b0;
      p1_data_q   <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
    end else if (sdr_cke) begin
      mode_q      <= mode_d;
      bank_open_q <= bank_open_d;
      row_q       <= row_d;
      proto_err_q <= proto_err_d;
      st_q        <= st_d;
      bst_ba_q    <= bst_ba_d;
      bst_col_q   <= bst_col_d;
      rem_q       <= rem_d;
      bst_ap_q    <= bst_ap_d;
      rd_vld_q    <= rd_vld_d;
      p1_vld_q    <= p1_vld_d;
      p1_data_q   <= p1_data_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
    end
  end

  // Array: not reset. A read and a write to the same word in one cycle
  // returns the old contents.
  always_ff @(posedge sdram_clk) begin
    if (sdr_cke) begin
      for (int b = 0; b < SDR_BW; b++) begin
        if (beat_vld && !beat_rd && !sdr_dqm[b]) mem[beat_idx][b*8 +: 8] <= sdr_dq_in[b*8 +: 8];
      end
      if (beat_vld && beat_rd) rd_data_q <= mem[beat_idx];
    end
  end

`ifdef SDRC_DEV_RSP_TIMING_CHK_EN
  // Saturating counters hold "edges since event minus one"; 7 = long ago.
  logic [3:0][2:0] act_cnt_q, act_cnt_d;
  logic [3:0][2:0] pre_cnt_q, pre_cnt_d;
  logic [2:0]      ref_cnt_q, ref_cnt_d;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      act_cnt_d[b] = (act_cnt_q[b] == 3'd7) ? 3'd7 : act_cnt_q[b] + 3'd1;
      pre_cnt_d[b] = (pre_cnt_q[b] == 3'd7) ? 3'd7 : pre_cnt_q[b] + 3'd1;
    end
    ref_cnt_d = (ref_cnt_q == 3'd7) ? 3'd7 : ref_cnt_q + 3'd1;
    if (cmd == CMD_ACT) act_cnt_d[sdr_ba] = 3'd0;
    if (cmd == CMD_PRE) begin
      if (sdr_addr[10]) pre_cnt_d = '0;
      else              pre_cnt_d[sdr_ba] = 3'd0;
    end
    if (cmd == CMD_REF) ref_cnt_d = 3'd0;
    tim_err = (is_rw && (act_cnt_q[sdr_ba] == 3'd0))
            | ((cmd == CMD_ACT) && (pre_cnt_q[sdr_ba] == 3'd0))
            | ((cmd != CMD_NOP) && (ref_cnt_q < 3'd6));
  end

  always_ff @(posedge sdram_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      act_cnt_q <= '1;
      pre_cnt_q <= '1;
      ref_cnt_q <= '1;
    end else if (sdr_cke) begin
      act_cnt_q <= act_cnt_d;
      pre_cnt_q <= pre_cnt_d;
      ref_cnt_q <= ref_cnt_d;
    end
  end
`else
  assign tim_err = 1'b0;
`endif

  assign sdr_dq_out = dq_out_q;
  assign sdr_dq_oe  = dq_oe_q;
  assign bank_open  = bank_open_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_sdrc_dev_rsp.sv
// tb_sdrc_dev_rsp - bench for sdrc_dev_rsp: directed scenarios plus a
// randomized write/read loop, checked against a word-level memory model.
module tb_sdrc_dev_rsp;
  localparam int DW = 16;
  localparam int AW = 13;
  localparam int COLW = 8;
  localparam int MAW = 12;
  localparam logic [2:0] C_LMR = 3'b000, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_BT = 3'b110, C_NOP = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cke = 1'b1;
  logic cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0] ba = '0;
  logic [AW-1:0] addr = '0;
  logic [1:0] dqm = '0;
  logic [DW-1:0] dq_in = '0;
  logic [DW-1:0] dq_out;
  logic dq_oe;
  logic [3:0] bank_open;
  logic proto_err;

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  sdrc_dev_rsp dut (
    .sdram_clk (clk),   .sdram_rst (rst),     .sdr_cke  (cke),
    .sdr_cs_n  (cs_n),  .sdr_ras_n (ras_n),   .sdr_cas_n(cas_n),  .sdr_we_n(we_n),
    .sdr_ba    (ba),    .sdr_addr  (addr),    .sdr_dqm  (dqm),    .sdr_dq_in(dq_in),
    .sdr_dq_out(dq_out),.sdr_dq_oe (dq_oe),   .bank_open(bank_open), .proto_err(proto_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [DW-1:0] mem_m [int];
  logic [AW-1:0] row_m [4];
  logic [3:0]    open_m;
  logic [AW-1:0] mode_m;
  logic          err_m;
  logic [DW-1:0] wd [8];
  logic [1:0]    wm [8];

  function automatic int bl_m();
    case (mode_m[2:0])
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int cl_m();
    return (mode_m[6:4] == 3'd2) ? 2 : 3;
  endfunction

  function automatic int idx_m(input int b, input int col);
    return ((int'(row_m[b]) << (2 + COLW)) + (b << COLW) + col) & ((1 << MAW) - 1);
  endfunction

  function automatic int col_k(input int col, input int k);
    int bl;
    bl = bl_m();
    return (col / bl) * bl + (col + k) % bl;
  endfunction

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            exp_edge_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  function automatic void push_exp(input int b, input int col, input int nb, input int n, input int cl);
    for (int k = 0; k < nb; k++) begin
      exp_q.push_back(mem_m[idx_m(b, col_k(col, k))]);
      exp_edge_q.push_back(n + k + cl - 1);
    end
  endfunction

  logic [DW-1:0] mon_d;
  int            mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (dq_oe) begin
        if (exp_q.size() == 0) begin
          check("rd_unexpected_oe", dq_oe, 0);
        end else begin
          mon_d = exp_q.pop_front();
          mon_e = exp_edge_q.pop_front();
          check("rd_data", dq_out, mon_d);
          check("rd_edge", edge_cnt, mon_e);
        end
      end else if (exp_edge_q.size() > 0 && exp_edge_q[0] <= edge_cnt) begin
        check("rd_missing_oe", dq_oe, 1);
        mon_d = exp_q.pop_front();
        mon_e = exp_edge_q.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [1:0] m);
    {ras_n, cas_n, we_n} = c;
    cs_n  = (c == C_NOP);
    ba    = b;
    addr  = a;
    dq_in = d;
    dqm   = m;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    repeat (n) drive(C_NOP, 2'd0, '0, '0, '0);
  endtask

  task automatic activate(input int b, input logic [AW-1:0] row);
    logic [1:0] bb;
    bb = b[1:0];
    if (open_m[b]) err_m = 1'b1;
    open_m[b] = 1'b1;
    row_m[b]  = row;
    drive(C_ACT, bb, row, '0, '0);
    check("proto_err_after_act", proto_err, err_m);
    nop(2);
  endtask

  task automatic precharge_all();
    logic [AW-1:0] a;
    a = '0;
    a[10] = 1'b1;
    open_m = '0;
    drive(C_PRE, 2'd0, a, '0, '0);
    nop(2);
  endtask

  task automatic load_mode(input logic [AW-1:0] a);
    if (|open_m) err_m = 1'b1;
    else         mode_m = a;
    drive(C_LMR, 2'd0, a, '0, '0);
    nop(2);
  endtask

  task automatic write_burst(input int b, input int col);
    int bl, i;
    bit ok;
    logic [AW-1:0] a;
    logic [DW-1:0] t;
    logic [1:0] bb;
    bb = b[1:0];
    bl = bl_m();
    ok = open_m[b];
    if (!ok) err_m = 1'b1;
    a = '0;
    a[COLW-1:0] = col[COLW-1:0];
    for (int k = 0; k < bl; k++) begin
      if (ok) begin
        i = idx_m(b, col_k(col, k));
        if (!mem_m.exists(i)) mem_m[i] = 'x;
        t = mem_m[i];
        for (int l = 0; l < 2; l++) if (!wm[k][l]) t[l*8 +: 8] = wd[k][l*8 +: 8];
        mem_m[i] = t;
      end
      if (k == 0) drive(C_WR, bb, a, wd[k], wm[k]);
      else        drive(C_NOP, bb, '0, wd[k], wm[k]);
    end
    nop(1);
  endtask

  // stop > 0: BURST TERMINATE is sampled at edge n+stop, so beats 0..stop-1 return.
  task automatic read_burst(input int b, input int col, input bit ap, input int stop);
    int bl, cl, nb, n;
    bit ok;
    logic [AW-1:0] a;
    logic [1:0] bb;
    bb = b[1:0];
    bl = bl_m();
    cl = cl_m();
    ok = open_m[b];
    nb = (stop > 0) ? stop : bl;
    a = '0;
    a[COLW-1:0] = col[COLW-1:0];
    a[10] = ap;
    if (!ok) err_m = 1'b1;
    n = edge_cnt + 1;
    if (ok) push_exp(b, col, nb, n, cl);
    for (int k = 0; k < bl; k++) begin
      if (k == 0)                    drive(C_RD, bb, a, '0, '0);
      else if (stop > 0 && k == stop) drive(C_BT, 2'd0, '0, '0, '0);
      else                           drive(C_NOP, 2'd0, '0, '0, '0);
      if (k == 0) check("proto_err_after_rd", proto_err, err_m);
      if (ap && ok && stop == 0) check("bank_open_autopre", bank_open[b], (k == bl - 1) ? 0 : 1);
    end
    if (ap && ok && stop == 0) open_m[b] = 1'b0;
    nop(cl + 2);
  endtask

  // ---------------- test sequence ----------------
  int b, col, rc, n;
  logic [AW-1:0] r0;

  initial begin
    mode_m = 13'h030;
    open_m = '0;
    err_m  = 1'b0;
    for (int i = 0; i < 4; i++) row_m[i] = '0;
    for (int k = 0; k < 8; k++) begin wd[k] = '0; wm[k] = '0; end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_dq_oe", dq_oe, 0);
    check("reset_dq_out", dq_out, 0);
    check("reset_bank_open", bank_open, 0);
    check("reset_proto_err", proto_err, 0);
    nop(2);

    // CL3 BL4 directed burst and wrap order
    load_mode(13'h032);
    activate(1, 13'd5);
    wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    write_burst(1, 8'h04);
    read_burst(1, 8'h04, 1'b0, 0);
    read_burst(1, 8'h06, 1'b0, 0);
    check("proto_err_clean", proto_err, err_m);

    // randomized BL4 traffic over all banks with random byte masks
    activate(0, 13'($urandom_range(0, 8191)));
    activate(2, 13'($urandom_range(0, 8191)));
    activate(3, 13'($urandom_range(0, 8191)));
    for (int it = 0; it < 12; it++) begin
      b   = $urandom_range(0, 3);
      col = $urandom_range(0, 255);
      for (int k = 0; k < 8; k++) begin wd[k] = DW'($urandom); wm[k] = 2'b00; end
      write_burst(b, col);
      for (int k = 0; k < 8; k++) begin wd[k] = DW'($urandom); wm[k] = 2'($urandom_range(0, 3)); end
      write_burst(b, col);
      rc = (col & ~3) | int'($urandom_range(0, 3));
      read_burst(b, rc, 1'b0, 0);
    end
    check("proto_err_random", proto_err, err_m);
    check("bank_open_random", bank_open, open_m);

    // CL2 BL8 with a masked beat over AAAA
    precharge_all();
    check("bank_open_pre_all", bank_open, open_m);
    load_mode(13'h023);
    r0 = 13'($urandom_range(0, 8191));
    activate(0, r0);
    for (int k = 0; k < 8; k++) begin wd[k] = 16'hAAAA; wm[k] = 2'b00; end
    write_burst(0, 8'h10);
    for (int k = 0; k < 8; k++) begin wd[k] = DW'($urandom); wm[k] = (k == 3) ? 2'b10 : 2'b00; end
    write_burst(0, 8'h10);
    read_burst(0, 8'h10, 1'b0, 0);

    // terminated burst, then auto-precharge read
    read_burst(0, 8'h13, 1'b0, 3);
    read_burst(0, 8'h10, 1'b1, 0);
    check("bank_open_after_ap", bank_open, open_m);

    // protocol errors
    read_burst(3, 8'h00, 1'b0, 0);
    check("proto_err_sticky", proto_err, err_m);
    activate(0, r0);
    load_mode(13'h030);
    read_burst(0, 8'h10, 1'b0, 0);
    check("proto_err_sticky2", proto_err, err_m);

    // reset in the middle of a read burst
    n = edge_cnt + 1;
    push_exp(0, 8'h10, bl_m(), n, cl_m());
    drive(C_RD, 2'd0, 13'h010, '0, '0);
    nop(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_edge_q.delete();
    #1;
    check("midrst_dq_oe", dq_oe, 0);
    check("midrst_dq_out", dq_out, 0);
    check("midrst_bank_open", bank_open, 0);
    check("midrst_proto_err", proto_err, 0);
    mode_m = 13'h030;
    open_m = '0;
    err_m  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nop(2);

    // default mode after reset: BL1, CL3
    activate(1, 13'd3);
    wd[0] = DW'($urandom);
    wm[0] = 2'b00;
    write_burst(1, 8'h22);
    read_burst(1, 8'h22, 1'b0, 0);
    activate(1, 13'd3);
    nop(3);
    check("proto_err_hold", proto_err, err_m);

    nop(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
